// File: rtl/cache_types_pkg.sv
// Shared types and geometry for the line-to-burst memory responder.
package cache_types_pkg;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 8 * (2 ** S_OFFSET);
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;
  localparam int BEAT_W    = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } burst_state_t;

  // Clear the byte-offset bits so the burst always starts on a line boundary.
  function automatic logic [31:0] align_line_addr(input logic [31:0] addr);
    return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index within a line burst; wraps to zero after the last beat.
module burst_beat_counter
  import cache_types_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [BEAT_W-1:0] count,
  output logic              last
);

  logic [BEAT_W-1:0] count_q;
  logic [BEAT_W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {BEAT_W{1'b0}};
    end else if (inc) begin
      count_d = count_q + BEAT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {BEAT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == BEAT_W'(NUM_BEATS - 1));

endmodule

// File: rtl/line_burst_responder.sv
// Converts one line read/write into a NUM_BEATS-beat burst on the narrow
// memory port and returns a single-cycle line response.
module line_burst_responder
  import cache_types_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read,
  input  logic               line_write,
  input  logic [31:0]        line_address,
  input  logic [S_LINE-1:0]  line_wdata,
  output logic [S_LINE-1:0]  line_rdata,
  output logic               line_resp,
  output logic               burst_read,
  output logic               burst_write,
  output logic [31:0]        burst_address,
  output logic [S_BURST-1:0] burst_wdata,
  input  logic [S_BURST-1:0] burst_rdata,
  input  logic               burst_resp
);

  burst_state_t      state_q;
  burst_state_t      state_d;
  logic [31:0]       addr_q;
  logic [31:0]       addr_d;
  logic [S_LINE-1:0] wdata_q;
  logic [S_LINE-1:0] wdata_d;
  logic [S_LINE-1:0] rdata_q;
  logic [S_LINE-1:0] rdata_d;
  logic              resp_q;
  logic              resp_d;
  logic              rd_q;
  logic              rd_d;
  logic              wr_q;
  logic              wr_d;

  logic [BEAT_W-1:0] beat;
  logic              beat_last;
  logic              beat_clear;
  logic              beat_inc;
  logic              in_burst;

  assign in_burst   = (state_q == RD) || (state_q == WR);
  assign beat_clear = (state_q == IDLE);
  assign beat_inc   = in_burst && burst_resp;

  burst_beat_counter u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (beat_clear),
    .inc   (beat_inc),
    .count (beat),
    .last  (beat_last)
  );

  // State, control outputs and line datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= {S_LINE{1'b0}};
      rdata_q <= {S_LINE{1'b0}};
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Next state: a write beats a simultaneous read; the read is picked up
  // again from IDLE if the requester is still holding it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          state_d = WR;
        end else if (line_read) begin
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD, WR: begin
        if (burst_resp && beat_last) begin
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; controls are decoded from the next
  // state so they leave registers aligned with the state they describe.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if ((state_q == IDLE) && (line_read || line_write)) begin
      addr_d = align_line_addr(line_address);
    end else begin
      addr_d = addr_q;
    end

    if ((state_q == IDLE) && line_write) begin
      wdata_d = line_wdata;
    end else begin
      wdata_d = wdata_q;
    end

    if ((state_q == RD) && burst_resp) begin
      rdata_d[S_BURST*int'(beat) +: S_BURST] = burst_rdata;
    end else begin
      rdata_d = rdata_q;
    end

    rd_d   = (state_d == RD);
    wr_d   = (state_d == WR);
    resp_d = (state_d == DONE);
  end

  assign line_rdata    = rdata_q;
  assign line_resp     = resp_q;
  assign burst_read    = rd_q;
  assign burst_write   = wr_q;
  assign burst_address = addr_q;
  assign burst_wdata   = wdata_q[S_BURST*int'(beat) +: S_BURST];

endmodule

// File: tb/tb_line_burst_responder.sv
// Self-checking bench for line_burst_responder: transaction-level reference
// model, per-cycle compare, directed scenarios and randomized traffic.
module tb_line_burst_responder;

  localparam int NB = 4;
  localparam int BW = 64;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_read, line_write;
  logic [31:0]   line_address;
  logic [LW-1:0] line_wdata, line_rdata;
  logic          line_resp, burst_read, burst_write;
  logic [31:0]   burst_address;
  logic [BW-1:0] burst_wdata, burst_rdata;
  logic          burst_resp;

  int n_checks = 0;
  int n_fail   = 0;

  line_burst_responder dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: what the responder is doing, in transaction terms.
  // kind 0 = waiting for a request, 1 = reading beats, 2 = writing beats,
  // 3 = reporting completion. beats = number of beats already transferred.
  int            m_kind;
  int            m_beats;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_wline;
  logic [LW-1:0] m_rline;

  // Advance the reference model once per clock.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kind <= 0; m_beats <= 0; m_addr <= '0; m_wline <= '0; m_rline <= '0;
    end else begin
      if (m_kind == 0) begin
        if (line_write || line_read) begin
          m_addr  <= line_address & 32'hFFFF_FFE0;
          m_beats <= 0;
          m_kind  <= line_write ? 2 : 1;
          if (line_write) m_wline <= line_wdata;
        end
      end else if (m_kind == 3) begin
        m_kind <= 0;
      end else if (burst_resp) begin
        if (m_kind == 1) m_rline[BW*m_beats +: BW] <= burst_rdata;
        if (m_beats + 1 == NB) begin
          m_kind  <= 3;
          m_beats <= 0;
        end else begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("burst_read", burst_read, m_kind == 1);
      chk("burst_write", burst_write, m_kind == 2);
      chk("line_resp", line_resp, m_kind == 3);
      chk("burst_address", burst_address, m_addr);
      chk("line_rdata", line_rdata, m_rline);
      if (m_kind == 2) chk("burst_wdata", burst_wdata, m_wline[BW*m_beats +: BW]);
    end
  end

  // Memory side stimulus state.
  bit            zero_wait = 1'b1;
  bit            noise_en  = 1'b0;
  bit            pat[$];
  logic [BW-1:0] rdq[$];
  logic [BW-1:0] rd_hist[$];
  logic [31:0]   seen_addr;
  logic [BW-1:0] seen_wbeat;

  task automatic mem_drive();
    bit r;
    logic [BW-1:0] d;
    if (burst_read || burst_write) begin
      if (pat.size() > 0) r = pat.pop_front();
      else if (zero_wait) r = 1'b1;
      else r = ($urandom_range(0, 2) != 0);
      burst_resp = r;
      d = {$urandom, $urandom};
      if (r && burst_read) begin
        if (rdq.size() > 0) d = rdq.pop_front();
        rd_hist.push_back(d);
      end
      burst_rdata = d;
    end else begin
      burst_resp  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      burst_rdata = {$urandom, $urandom};
    end
  endtask

  // Present a request and follow it to completion; the requester drops its
  // request at the edge that ends the completion cycle.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [LW-1:0] wd, input int exp_resps,
                        input int exp_lat, input int trail, input bit scramble);
    int k, nresp, n;
    bit both, is_read;
    both = rd & wr;
    line_address = addr; line_wdata = wd; line_read = rd; line_write = wr;
    k = 0; nresp = 0;
    while (nresp < exp_resps && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        seen_addr  = burst_address;
        seen_wbeat = burst_wdata;
      end
      mem_drive();
      if (scramble && k == 2) begin
        line_address = $urandom;
        line_wdata   = {8{$urandom}};
      end
      if (line_resp) begin
        nresp++;
        if (nresp == 1 && exp_lat >= 0) chk("latency", k, exp_lat);
        is_read = !wr || (both && nresp == 2);
        n = rd_hist.size();
        if (is_read && n >= NB)
          chk("rdata_assembled", line_rdata,
              {rd_hist[n-1], rd_hist[n-2], rd_hist[n-3], rd_hist[n-4]});
        if (nresp == 1 && both) line_write = 1'b0;
        else begin line_read = 1'b0; line_write = 1'b0; end
      end
    end
    chk("resp_count", nresp, exp_resps);
    for (int i = 0; i < trail; i++) begin
      @(negedge clk);
      mem_drive();
      chk("no_extra_burst", {burst_read, burst_write, line_resp}, 3'b000);
    end
  endtask

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W2 = 64'hA5A5_0F0F_5A5A_F0F0;
  localparam logic [63:0] W3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [LW-1:0] RD_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  initial begin
    rst = 1'b1;
    line_read = 1'b0; line_write = 1'b0; line_address = '0; line_wdata = '0;
    burst_rdata = '0; burst_resp = 1'b0;
    #1;
    chk("reset_burst_read", burst_read, 1'b0);
    chk("reset_burst_write", burst_write, 1'b0);
    chk("reset_line_resp", line_resp, 1'b0);
    chk("reset_burst_address", burst_address, 32'h0);
    chk("reset_burst_wdata", burst_wdata, 64'h0);
    chk("reset_line_rdata", line_rdata, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Spurious burst_resp while idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("spurious_idle", {burst_read, burst_write, line_resp, burst_address}, 35'h0);
      chk("spurious_rdata", line_rdata, '0);
      burst_resp = (i < 3);
    end

    // Zero-wait read.
    zero_wait = 1'b1;
    rdq.push_back(64'h1111_1111_1111_1111); rdq.push_back(64'h2222_2222_2222_2222);
    rdq.push_back(64'h3333_3333_3333_3333); rdq.push_back(64'h4444_4444_4444_4444);
    do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1, 5, 2, 1'b0);
    chk("read_addr", seen_addr, 32'h0000_1220);
    chk("read_line", line_rdata, RD_LINE);

    // Write with stalled beats.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_txn(1'b0, 1'b1, 32'h8000_00E0, {W3, W2, W1, W0}, 1, 8, 2, 1'b0);
    chk("write_addr", seen_addr, 32'h8000_00E0);
    chk("write_first_beat", seen_wbeat, W0);
    chk("write_keeps_rdata", line_rdata, RD_LINE);

    // Simultaneous read + write to the same address: write first, then read.
    do_txn(1'b1, 1'b1, 32'h0000_0400, {W0, W1, W2, W3}, 2, 5, 2, 1'b0);
    chk("both_first_is_write", seen_addr, 32'h0000_0400);

    // Back-to-back reads.
    do_txn(1'b1, 1'b0, 32'h0000_0100, '0, 1, 5, 0, 1'b0);
    chk("b2b_addr0", seen_addr, 32'h0000_0100);
    @(negedge clk);
    mem_drive();
    do_txn(1'b1, 1'b0, 32'h0000_0200, '0, 1, 5, 3, 1'b0);
    chk("b2b_addr1", seen_addr, 32'h0000_0200);

    // Reset in the middle of a read burst.
    line_address = 32'h0000_0040; line_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_drive();
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_burst_read", burst_read, 1'b0);
    chk("rst_mid_line_rdata", line_rdata, '0);
    chk("rst_mid_line_resp", line_resp, 1'b0);
    chk("rst_mid_burst_address", burst_address, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 1, 5, 1, 1'b0);

    // Randomized traffic with memory stalls and idle-time noise.
    zero_wait = 1'b0;
    noise_en  = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_txn(kind != 1, kind != 0, $urandom, {8{$urandom}}, (kind == 2) ? 2 : 1, -1,
             $urandom_range(0, 2), kind != 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_burst_responder.md
Name: line_burst_responder

Overview:
- Memory-side responder for the cache's line-wide downstream interface.
- Accepts one line read or line write (address plus s_line data) and converts it to an s_line/s_burst-beat burst on a narrow physical-memory port.
- Returns a single-cycle line response.
- Sits between the last cache level and main memory; pairs with the cache datapath's downstream_* signals.

Parameters:
- s_offset, 5, byte-offset bits of a line.
- s_line, 256, line width in bits (8*2**s_offset).
- s_burst, 64, width of one memory beat in bits.
- num_beats, s_line/s_burst (4), beats per line; must be a power of two ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- line_read  in  1  line read request; held until line_resp.
- line_write  in  1  line write request; held until line_resp.
- line_address  in  32  request address; offset bits need not be zero.
- line_wdata  in  s_line  write line.
- line_rdata  out  s_line  read line; valid when line_resp=1.
- line_resp  out  1  one-cycle completion pulse.
- burst_read  out  1  memory read request.
- burst_write  out  1  memory write request.
- burst_address  out  32  line-aligned address: {line_address[31:s_offset], s_offset'b0}.
- burst_wdata  out  s_burst  current write beat.
- burst_rdata  in  s_burst  current read beat.
- burst_resp  in  1  beat accepted/returned this cycle.

Behaviour:
- Reset (async, any state): state=IDLE, beat=0, line_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, line_rdata=0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - line_write=1: latch aligned address and line_wdata, beat=0, go WR.
  - Else line_read=1: latch aligned address, beat=0, go RD.
  - Both asserted: write wins. Read stays pending and is served from IDLE after DONE if still held.
  - Request to burst start: 1 cycle.
- RD:
  - burst_read=1, burst_address held.
  - On each cycle with burst_resp=1, line_rdata[s_burst*beat +: s_burst] <= burst_rdata and beat++.
  - On the beat where beat==num_beats-1 and burst_resp=1, go DONE, burst_read=0 next cycle.
  - burst_resp=0 cycles stall with no change; gaps of any length are legal.
- WR:
  - burst_write=1, burst_wdata = latched_wdata[s_burst*beat +: s_burst] (combinational from beat).
  - burst_resp advances beat. The last beat goes DONE.
- DONE:
  - line_resp=1 for exactly one cycle, then IDLE.
  - Requester must drop line_read/line_write at the clock edge ending the DONE cycle. A request still high in IDLE is treated as new.
- line_rdata holds its last value until overwritten by the next read's beats. A write never alters it.
- burst_resp in IDLE or DONE is ignored.
- Beat counter width $clog2(num_beats), wraps to 0 after the last beat.
- Line-side inputs change mid-burst: ignored (address/wdata latched).
- Reset mid-burst: immediate abort, all outputs to reset values, no line_resp.
- Latency with zero-wait memory (burst_resp held 1): request seen in IDLE at cycle 0, beats in cycles 1..num_beats, line_resp in cycle num_beats+1.

Decomposition:
- Shared package cache_types_pkg: enum burst_state_t {IDLE, RD, WR, DONE}; constants S_LINE, S_BURST, NUM_BEATS, BEAT_W=$clog2(NUM_BEATS).
- One sub-module: burst_beat_counter.
  - Inputs: clk, rst, clear, inc.
  - Outputs: count, last (count==NUM_BEATS-1).
  - Reused by future write-back buffer.
- Data assembly/slicing stays in the top module.

Test Plan:
- Read, zero-wait: line_read=1, addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with burst_resp=1 each cycle.
  - burst_address=0x0000_1220.
  - line_resp pulses at cycle 5.
  - line_rdata = {0x44..,0x33..,0x22..,0x11..} (beat0 in low bits).
- Write, stalled beats: line_write=1, addr 0x8000_00E0, wdata = 4 distinct 64-bit words; burst_resp pattern 1,0,0,1,0,1,1.
  - burst_wdata steps word0..word3 only on resp cycles.
  - burst_write drops after the 4th resp.
  - line_resp=1 exactly once.
  - line_rdata unchanged.
- Simultaneous read+write: both asserted with the same address.
  - WR burst runs first, then line_resp.
  - Read held: RD burst starts the next IDLE cycle, second line_resp follows.
- Back-to-back reads to 0x100 then 0x200: requester drops at the DONE edge and reasserts the next cycle.
  - Two distinct bursts, burst_address 0x100 then 0x200.
  - No spurious third burst.
- Reset mid-burst: rst=1 asynchronously after beat 2 of a read.
  - burst_read=0 and line_rdata=0 immediately, no line_resp.
  - After rst=0 with line_read still high, a fresh burst starts with beat=0.
- Spurious burst_resp=1 in IDLE for 3 cycles with no request: no state change, all outputs stay 0.
